// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared defaults and FSM state type for the memory arbiter
package mem_arb_pkg;

   localparam int ARB_ADDR_W       = 32;
   localparam int ARB_DATA_W       = 32;
   localparam int ARB_TIMEOUT      = 16;
   localparam int ARB_MAX_D_STREAK = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_D = 2'd1,
      ST_GRANT_I = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - grant watchdog; expired is high in the last allowed grant cycle
module arb_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port unified memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int TIMEOUT      = ARB_TIMEOUT,
   parameter int MAX_D_STREAK = ARB_MAX_D_STREAK
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_f,
   output logic              stall_m,
   output logic              err_timeout
);

   localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

   arb_state_t          r_state;
   arb_state_t          w_state_next;
   logic [STREAK_W-1:0] r_streak;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_i_rdata;
   logic [DATA_W-1:0]   r_d_rdata;
   logic                r_i_ready;
   logic                r_d_ready;
   logic                r_err_timeout;

   logic w_in_grant;
   logic w_expired;
   logic w_done;
   logic w_turnaround;
   logic w_i_pend;
   logic w_d_pend;
   logic w_streak_full;
   logic w_take_d;
   logic w_take_i;

   assign w_in_grant    = (r_state != ST_IDLE);
   assign w_done        = w_in_grant & (mem_ack | w_expired);
   assign w_i_pend      = i_req & ~r_i_ready;
   assign w_d_pend      = d_req & ~r_d_ready;
   assign w_streak_full = (r_streak >= STREAK_W'(MAX_D_STREAK));
   // The completion cycle is a turnaround: no grant is issued while either ready
   // pulses, so a port that keeps its request up re-arbitrates on equal terms.
   assign w_turnaround  = r_i_ready | r_d_ready;

   arb_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (w_in_grant),
      .i_clear  (~w_in_grant),
      .o_expired(w_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_take_d     = 1'b0;
      w_take_i     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_turnaround) begin
               if (w_d_pend && !(w_i_pend && w_streak_full)) begin
                  w_take_d     = 1'b1;
                  w_state_next = ST_GRANT_D;
               end else if (w_i_pend) begin
                  w_take_i     = 1'b1;
                  w_state_next = ST_GRANT_I;
               end
            end
         end
         ST_GRANT_D, ST_GRANT_I: begin
            if (w_done) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_streak      <= '0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_i_rdata     <= '0;
         r_d_rdata     <= '0;
         r_i_ready     <= 1'b0;
         r_d_ready     <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_i_ready <= 1'b0;
         r_d_ready <= 1'b0;

         if (!i_req || w_take_i) begin
            r_streak <= '0;
         end else if (w_take_d && !w_streak_full) begin
            r_streak <= r_streak + 1'b1;
         end

         if (w_take_d) begin
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
         end else if (w_take_i) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
         end

         // A timed-out access completes with zero data and never reaches memory.
         if (w_done) begin
            if (r_state == ST_GRANT_I) begin
               r_i_ready <= 1'b1;
               r_i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
               r_d_ready <= 1'b1;
               if (!r_mem_we) begin
                  r_d_rdata <= mem_ack ? mem_rdata : '0;
               end
            end
            if (!mem_ack) begin
               r_err_timeout <= 1'b1;
            end
         end
      end
   end

   assign mem_req     = w_in_grant;
   assign mem_we      = r_mem_we & w_in_grant;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign i_rdata     = r_i_rdata;
   assign d_rdata     = r_d_rdata;
   assign i_ready     = r_i_ready;
   assign d_ready     = r_d_ready;
   assign err_timeout = r_err_timeout;
   assign stall_f     = i_req & ~r_i_ready;
   assign stall_m     = d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

   localparam logic [31:0] KEY = 32'h20480005;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } grant_t;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_f;
   logic        stall_m;
   logic        err_timeout;

   int n_pass  = 0;
   int n_total = 0;
   int ack_delay = 1;
   logic [31:0] last_d = 32'h0;

   grant_t      grant_q[$];
   logic [31:0] i_q[$];
   logic [31:0] d_q[$];

   mem_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_ready    (i_ready),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_ready    (d_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .stall_f    (stall_f),
      .stall_m    (stall_m),
      .err_timeout(err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: ack on the ack_delay-th grant cycle (0 = never), data = addr ^ KEY.
   initial begin
      int cyc;
      cyc       = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req) cyc = cyc + 1;
         else         cyc = 0;
         if (mem_req && ack_delay != 0 && cyc == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr ^ KEY;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
         end
      end
   end

   // Scoreboard: grant starts and ready pulses are popped against expectations.
   initial begin
      logic        prev_req;
      grant_t      g;
      logic [31:0] e;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req && !prev_req) begin
            n_total++;
            if (grant_q.size() == 0) begin
               $display("FAIL grant_unexpected got we=%b addr=%h want none", mem_we, mem_addr);
            end else begin
               g = grant_q.pop_front();
               if (mem_we !== g.we || mem_addr !== g.addr || (g.we && mem_wdata !== g.wdata))
                  $display("FAIL grant_check got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                           mem_we, mem_addr, mem_wdata, g.we, g.addr, g.wdata);
               else n_pass++;
            end
         end
         if (i_ready) begin
            n_total++;
            if (i_q.size() == 0) begin
               $display("FAIL i_ready_unexpected got rdata=%h want none", i_rdata);
            end else begin
               e = i_q.pop_front();
               if (i_rdata !== e) $display("FAIL i_rdata got %h want %h", i_rdata, e);
               else n_pass++;
            end
         end
         if (d_ready) begin
            n_total++;
            if (d_q.size() == 0) begin
               $display("FAIL d_ready_unexpected got rdata=%h want none", d_rdata);
            end else begin
               e = d_q.pop_front();
               if (d_rdata !== e) $display("FAIL d_rdata got %h want %h", d_rdata, e);
               else n_pass++;
            end
         end
         prev_req = mem_req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic test_reset();
      rst_n = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({mem_req, mem_we, i_ready, d_ready, err_timeout, stall_f, stall_m} !== 7'b0)
         $display("FAIL reset_ctrl got %b want 0000000",
                  {mem_req, mem_we, i_ready, d_ready, err_timeout, stall_f, stall_m});
      else n_pass++;
      n_total++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0)
         $display("FAIL reset_data got addr=%h wdata=%h irdata=%h drdata=%h want 0",
                  mem_addr, mem_wdata, i_rdata, d_rdata);
      else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_total++;
      if (mem_req !== 1'b0) $display("FAIL idle_no_req got mem_req=%b want 0", mem_req);
      else n_pass++;
   endtask

   task automatic test_fetch();
      int  cnt;
      bit  done;
      ack_delay = 2;
      i_addr = 32'h00400000;
      grant_q.push_back('{we: 1'b0, addr: 32'h00400000, wdata: 32'h0});
      i_q.push_back(32'h20080005);
      i_req = 1'b1;
      #1;
      n_total++;
      if (stall_f !== 1'b1) $display("FAIL stall_f_pending got %b want 1", stall_f);
      else n_pass++;
      cnt = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mem_req) cnt++;
         if (i_ready) done = 1;
      end
      n_total++;
      if (!done) $display("FAIL fetch_timeout got no i_ready want i_ready");
      else n_pass++;
      n_total++;
      if (stall_f !== 1'b0) $display("FAIL stall_f_ready got %b want 0", stall_f);
      else n_pass++;
      i_req = 1'b0;
      n_total++;
      if (cnt != 2) $display("FAIL fetch_req_cycles got %0d want 2", cnt);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (stall_f !== 1'b0 || i_rdata !== 32'h20080005)
         $display("FAIL fetch_after got stall_f=%b rdata=%h want 0 20080005", stall_f, i_rdata);
      else n_pass++;
   endtask

   task automatic test_latency();
      ack_delay = 1;
      d_we = 1'b0;
      d_addr = 32'h10000040;
      last_d = 32'h10000040 ^ KEY;
      grant_q.push_back('{we: 1'b0, addr: 32'h10000040, wdata: 32'h0});
      d_q.push_back(last_d);
      d_req = 1'b1;
      @(negedge clk);
      n_total++;
      if (mem_req !== 1'b1 || d_ready !== 1'b0 || stall_m !== 1'b1)
         $display("FAIL latency_n1 got req=%b rdy=%b stall_m=%b want 1 0 1", mem_req, d_ready, stall_m);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (d_ready !== 1'b1 || mem_req !== 1'b0 || stall_m !== 1'b0)
         $display("FAIL latency_n2 got rdy=%b req=%b stall_m=%b want 1 0 0", d_ready, mem_req, stall_m);
      else n_pass++;
      d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_both();
      bit d_seen, i_seen, d_first;
      ack_delay = 1;
      d_we = 1'b1; d_addr = 32'h10010000; d_wdata = 32'hDEADBEEF;
      i_addr = 32'h00400004;
      grant_q.push_back('{we: 1'b1, addr: 32'h10010000, wdata: 32'hDEADBEEF});
      grant_q.push_back('{we: 1'b0, addr: 32'h00400004, wdata: 32'h0});
      d_q.push_back(last_d);
      i_q.push_back(32'h00400004 ^ KEY);
      i_req = 1'b1; d_req = 1'b1;
      d_seen = 0; i_seen = 0; d_first = 0;
      for (int c = 0; c < 40 && !(d_seen && i_seen); c++) begin
         @(negedge clk);
         if (mem_req && mem_we && d_seen) $display("FAIL write_after_done got mem_we=1 want 0");
         if (d_ready) begin d_req = 1'b0; d_seen = 1; d_first = !i_seen; end
         if (i_ready) begin i_req = 1'b0; i_seen = 1; end
      end
      d_we = 1'b0;
      n_total++;
      if (!(d_seen && i_seen && d_first))
         $display("FAIL both_order got d=%b i=%b dfirst=%b want 1 1 1", d_seen, i_seen, d_first);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_streak();
      int i_done;
      ack_delay = 1;
      d_we = 1'b0; d_addr = 32'h10000100; i_addr = 32'h00400008;
      for (int k = 0; k < 10; k++) begin
         if (k % 5 == 4) begin
            grant_q.push_back('{we: 1'b0, addr: 32'h00400008, wdata: 32'h0});
            i_q.push_back(32'h00400008 ^ KEY);
         end else begin
            grant_q.push_back('{we: 1'b0, addr: 32'h10000100, wdata: 32'h0});
            d_q.push_back(32'h10000100 ^ KEY);
         end
      end
      last_d = 32'h10000100 ^ KEY;
      i_req = 1'b1; d_req = 1'b1;
      i_done = 0;
      for (int c = 0; c < 200 && i_done < 2; c++) begin
         @(negedge clk);
         if (i_ready) i_done++;
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (i_done != 2 || grant_q.size() != 0 || d_q.size() != 0)
         $display("FAIL streak_pattern got fetches=%0d left_grants=%0d left_d=%0d want 2 0 0",
                  i_done, grant_q.size(), d_q.size());
      else n_pass++;
   endtask

   task automatic test_timeout();
      int cnt;
      bit done;
      n_total++;
      if (err_timeout !== 1'b0) $display("FAIL err_before got %b want 0", err_timeout);
      else n_pass++;
      ack_delay = 0;
      i_addr = 32'h00400010;
      grant_q.push_back('{we: 1'b0, addr: 32'h00400010, wdata: 32'h0});
      i_q.push_back(32'h0);
      i_req = 1'b1;
      cnt = 0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (mem_req) cnt++;
         if (i_ready) done = 1;
      end
      i_req = 1'b0;
      n_total++;
      if (!done || cnt != 16) $display("FAIL timeout_cycles got done=%b cycles=%0d want 1 16", done, cnt);
      else n_pass++;
      n_total++;
      if (err_timeout !== 1'b1) $display("FAIL err_set got %b want 1", err_timeout);
      else n_pass++;
      ack_delay = 1;
      i_addr = 32'h00400014;
      grant_q.push_back('{we: 1'b0, addr: 32'h00400014, wdata: 32'h0});
      i_q.push_back(32'h00400014 ^ KEY);
      @(negedge clk);
      i_req = 1'b1;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (i_ready) done = 1;
      end
      i_req = 1'b0;
      @(negedge clk);
      n_total++;
      if (!done || err_timeout !== 1'b1)
         $display("FAIL err_sticky got done=%b err=%b want 1 1", done, err_timeout);
      else n_pass++;
   endtask

   task automatic test_reset_mid_grant();
      bit seen;
      ack_delay = 0;
      d_we = 1'b0; d_addr = 32'h10000200;
      grant_q.push_back('{we: 1'b0, addr: 32'h10000200, wdata: 32'h0});
      d_req = 1'b1;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (mem_req) seen = 1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_total++;
      if (!seen || {mem_req, mem_we, d_ready, i_ready, err_timeout} !== 5'b0)
         $display("FAIL midreset_ctrl got seen=%b ctrl=%b want 1 00000",
                  seen, {mem_req, mem_we, d_ready, i_ready, err_timeout});
      else n_pass++;
      n_total++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0)
         $display("FAIL midreset_data got addr=%h wdata=%h irdata=%h drdata=%h want 0",
                  mem_addr, mem_wdata, i_rdata, d_rdata);
      else n_pass++;
      ack_delay = 1;
      grant_q.push_back('{we: 1'b0, addr: 32'h10000200, wdata: 32'h0});
      d_q.push_back(32'h10000200 ^ KEY);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (d_ready) seen = 1;
      end
      d_req = 1'b0;
      n_total++;
      if (!seen) $display("FAIL after_reset_grant got no d_ready want d_ready");
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_latency();
      test_both();
      test_streak();
      test_timeout();
      test_reset_mid_grant();
      n_total++;
      if (grant_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0)
         $display("FAIL scoreboard_drain got grants=%0d i=%0d d=%0d want 0 0 0",
                  grant_q.size(), i_q.size(), d_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, memory address width.
REQ-002 Parameter DATA_W, 32, memory data width.
REQ-003 Parameter TIMEOUT, 16, max cycles a grant waits for mem_ack.
REQ-004 Parameter MAX_D_STREAK, 4, max consecutive data grants while i_req pending.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_req  input  1  fetch-stage read request, held until i_ready.
REQ-008 i_addr  input  ADDR_W  fetch address, stable while i_req high.
REQ-009 i_rdata  output  DATA_W  fetched instruction, valid when i_ready high.
REQ-010 i_ready  output  1  one-cycle completion pulse, fetch port.
REQ-011 d_req  input  1  memory-stage request, held until d_ready.
REQ-012 d_we  input  1  1 = write, 0 = read.
REQ-013 d_addr  input  ADDR_W  data address, stable while d_req high.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_rdata  output  DATA_W  load data, valid when d_ready high and read.
REQ-016 d_ready  output  1  one-cycle completion pulse, data port.
REQ-017 mem_req  output  1  request to single-port unified memory.
REQ-018 mem_we  output  1  write enable to memory.
REQ-019 mem_addr  output  ADDR_W  memory address.
REQ-020 mem_wdata  output  DATA_W  memory write data.
REQ-021 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
REQ-022 mem_ack  input  1  memory completion, may assert same cycle as mem_req.
REQ-023 stall_f  output  1  fetch stall to hazard logic.
REQ-024 stall_m  output  1  memory-stage stall to hazard logic.
REQ-025 err_timeout  output  1  sticky timeout flag.

Function
REQ-026 FSM states SHALL be IDLE, GRANT_D, GRANT_I; at most one grant active.
REQ-027 IDLE: d_req -> GRANT_D, else i_req -> GRANT_I, else stay; priority overridden per REQ-028.
REQ-028 Streak counter SHALL count consecutive GRANT_D entries while i_req high; at MAX_D_STREAK, next grant with i_req high SHALL be GRANT_I; counter clears on GRANT_I entry or i_req low.
REQ-029 On grant entry, mem_addr/mem_we/mem_wdata SHALL be registered from winning port and held constant until state leaves GRANT_*; mem_we=0 for GRANT_I.
REQ-030 mem_req SHALL be 1 exactly while in GRANT_D or GRANT_I.
REQ-031 Cycle in GRANT_* with mem_ack=1: next edge latch mem_rdata into granted port's rdata (reads only), pulse that port's ready for one cycle, return to IDLE.
REQ-032 Minimum latency: req seen cycle N, mem_req cycle N+1, ready cycle N+2 with immediate ack.
REQ-033 In the cycle a port's ready is high, that port's req SHALL be masked from arbitration (no duplicate grant).
REQ-034 d_rdata SHALL be unchanged on write completion; i_rdata/d_rdata hold last value otherwise.
REQ-035 stall_f = i_req AND NOT i_ready; stall_m = d_req AND NOT d_ready; combinational.
REQ-036 Timeout counter SHALL count cycles in GRANT_*; reaching TIMEOUT without ack -> IDLE, ready pulse with rdata=0, write discarded, err_timeout set.
REQ-037 mem_ack outside GRANT_* SHALL be ignored.

Reset
REQ-038 rst_n low at a rising edge SHALL force IDLE, counters 0, mem_req/mem_we/i_ready/d_ready/err_timeout 0, mem_addr/mem_wdata/i_rdata/d_rdata 0.
REQ-039 Reset mid-grant SHALL abort with no ready pulse; mem_req low from the following cycle.

Structure
REQ-040 Shared package mem_arb_pkg SHALL hold state enum and default ADDR_W, DATA_W, TIMEOUT, MAX_D_STREAK.
REQ-041 Timeout counter SHALL be sub-module arb_timer (enable, clear, expired).

Verification
REQ-042 i_req only, addr 0x00400000, ack after 2 cycles data 0x20080005 -> mem_req 2 cycles, i_ready pulse, i_rdata=0x20080005, stall_f low after.
REQ-043 i_req and d_req same cycle, d_we=1 addr 0x10010000 wdata 0xDEADBEEF -> GRANT_D first, mem_we=1, d_ready, then GRANT_I, i_ready.
REQ-044 d_req held continuously with i_req high, ack immediate -> 4 data grants then 1 fetch grant, repeating.
REQ-045 Grant with mem_ack never asserted -> after 16 cycles ready pulse, rdata 0, err_timeout=1 until reset.
REQ-046 rst_n low 1 cycle during GRANT_D -> no d_ready, mem_req 0 next cycle, all outputs 0, normal grant after release.
